// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - shared vector opcode/funct constants and latency classes
package v_pkg;

    localparam logic [6:0] OPC_VLD    = 7'b0000111;
    localparam logic [6:0] OPC_VST    = 7'b0100111;
    localparam logic [6:0] OPC_OPV    = 7'b1010111;

    localparam logic [6:0] F7_VDIV16  = 7'b0000010;
    localparam logic [6:0] F7_VDIV32  = 7'b0000110;

    localparam logic [2:0] F3_OPIVV   = 3'b000;

    typedef enum logic [1:0] {
        LC_NONE,
        LC_ALU,
        LC_LD,
        LC_DIV
    } lat_class_e;

endpackage

// File: rtl/v_issue_classify.sv
// rtl/v_issue_classify.sv - maps an instruction to its vreg read/write set and latency class
module v_issue_classify
    import v_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    output logic        writes_vd_o,
    output logic        reads_vs1_o,
    output logic        reads_vs2_o,
    output logic        reads_vs3_o,
    output lat_class_e  lat_class_o
);

    always_comb begin
        writes_vd_o = 1'b0;
        reads_vs1_o = 1'b0;
        reads_vs2_o = 1'b0;
        reads_vs3_o = 1'b0;
        lat_class_o = LC_NONE;
        case (opcode_i)
            OPC_VLD: begin
                writes_vd_o = 1'b1;
                lat_class_o = LC_LD;
            end
            OPC_VST: begin
                reads_vs3_o = 1'b1;
            end
            OPC_OPV: begin
                writes_vd_o = 1'b1;
                reads_vs2_o = 1'b1;
                // vs1 is a vector operand only in the vector-vector form
                reads_vs1_o = (funct3_i == F3_OPIVV);
                if (funct7_i == F7_VDIV16 || funct7_i == F7_VDIV32)
                    lat_class_o = LC_DIV;
                else
                    lat_class_o = LC_ALU;
            end
            default: begin
                writes_vd_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/v_issue_ctrl.sv
// rtl/v_issue_ctrl.sv - vector issue controller with countdown writeback tracker
module v_issue_ctrl
    import v_pkg::*;
#(
    parameter int NPEND   = 4,
    parameter int LAT_LD  = 2,
    parameter int LAT_DIV = 8,
    parameter int LAT_ALU = 1,
    parameter int INST_DW = 32,
    parameter int VREG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid_i,
    input  logic [INST_DW-1:0] inst_i,
    output logic               inst_ready_o,
    input  logic               flush_i,
    output logic               issue_valid_o,
    output logic [INST_DW-1:0] issue_inst_o,
    output logic               wb_strobe_o,
    output logic [VREG_AW-1:0] wb_vd_o,
    output logic               busy_o
);

    localparam int LAT_MAX = (LAT_DIV > LAT_LD) ? ((LAT_DIV > LAT_ALU) ? LAT_DIV : LAT_ALU)
                                                : ((LAT_LD  > LAT_ALU) ? LAT_LD  : LAT_ALU);
    localparam int CW = $clog2(LAT_MAX) + 1;
    localparam int IW = (NPEND > 1) ? $clog2(NPEND) : 1;

    typedef struct packed {
        logic               valid;
        logic [VREG_AW-1:0] vd;
        logic [CW-1:0]      cnt;
    } ent_t;

    ent_t               ent_q [NPEND];
    ent_t               ent_d [NPEND];
    logic               issue_valid_q, issue_valid_d;
    logic [INST_DW-1:0] issue_inst_q, issue_inst_d;

    logic [VREG_AW-1:0] vd, vs1, vs2;
    logic               wr_vd, rd_vs1, rd_vs2, rd_vs3;
    lat_class_e         lat_class;
    logic [CW-1:0]      lat_w;
    logic               tracked;

    assign vd  = inst_i[11:7];
    assign vs1 = inst_i[19:15];
    assign vs2 = inst_i[24:20];

    v_issue_classify u_classify (
        .opcode_i    (inst_i[6:0]),
        .funct3_i    (inst_i[14:12]),
        .funct7_i    (inst_i[31:25]),
        .writes_vd_o (wr_vd),
        .reads_vs1_o (rd_vs1),
        .reads_vs2_o (rd_vs2),
        .reads_vs3_o (rd_vs3),
        .lat_class_o (lat_class)
    );

    always_comb begin
        lat_w = '0;
        case (lat_class)
            LC_LD:   lat_w = CW'(LAT_LD);
            LC_DIV:  lat_w = CW'(LAT_DIV);
            LC_ALU:  lat_w = CW'(LAT_ALU);
            default: lat_w = '0;
        endcase
    end

    assign tracked = wr_vd && (lat_class != LC_NONE);

    logic [NPEND-1:0] retiring;
    logic             hazard, collide, slot_ok, retire_hit, any_valid;
    logic [IW-1:0]    alloc_idx;
    logic [VREG_AW-1:0] retire_vd;

    always_comb begin
        retiring = '0;
        for (int i = 0; i < NPEND; i++)
            retiring[i] = ent_q[i].valid && (ent_q[i].cnt == CW'(1));
    end

    // Descending scan so the lowest free-or-retiring index wins allocation
    always_comb begin
        hazard     = 1'b0;
        collide    = 1'b0;
        slot_ok    = 1'b0;
        alloc_idx  = '0;
        retire_hit = 1'b0;
        retire_vd  = '0;
        any_valid  = 1'b0;
        for (int i = NPEND - 1; i >= 0; i--) begin
            if (ent_q[i].valid)
                any_valid = 1'b1;
            if (!ent_q[i].valid || retiring[i]) begin
                slot_ok   = 1'b1;
                alloc_idx = IW'(i);
            end
            if (retiring[i]) begin
                retire_hit = 1'b1;
                retire_vd  = ent_q[i].vd;
            end
            if (ent_q[i].valid && !retiring[i]) begin
                if ((rd_vs1 && ent_q[i].vd == vs1) ||
                    (rd_vs2 && ent_q[i].vd == vs2) ||
                    (rd_vs3 && ent_q[i].vd == vd)  ||
                    (wr_vd  && ent_q[i].vd == vd))
                    hazard = 1'b1;
            end
            if (ent_q[i].valid && (ent_q[i].cnt == lat_w + CW'(1)))
                collide = 1'b1;
        end
    end

    logic accept;

    assign inst_ready_o = !rst && !flush_i && !hazard
                          && !(tracked && !slot_ok) && !(tracked && collide);
    assign accept       = inst_valid_i && inst_ready_o;

    always_comb begin
        ent_d         = ent_q;
        issue_valid_d = 1'b0;
        issue_inst_d  = issue_inst_q;
        for (int i = 0; i < NPEND; i++) begin
            if (ent_q[i].valid) begin
                if (ent_q[i].cnt > CW'(1))
                    ent_d[i].cnt = ent_q[i].cnt - CW'(1);
                else
                    ent_d[i].valid = 1'b0;
            end
        end
        if (flush_i) begin
            for (int i = 0; i < NPEND; i++)
                ent_d[i].valid = 1'b0;
        end else if (accept) begin
            issue_valid_d = 1'b1;
            issue_inst_d  = inst_i;
            if (tracked)
                ent_d[alloc_idx] = '{valid: 1'b1, vd: vd, cnt: lat_w};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPEND; i++)
                ent_q[i] <= '0;
            issue_valid_q <= 1'b0;
            issue_inst_q  <= '0;
        end else begin
            ent_q         <= ent_d;
            issue_valid_q <= issue_valid_d;
            issue_inst_q  <= issue_inst_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_inst_o  = issue_inst_q;
    assign wb_strobe_o   = retire_hit;
    assign wb_vd_o       = retire_vd;
    assign busy_o        = any_valid || issue_valid_q;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb/tb_v_issue_ctrl.sv - scoreboard bench for v_issue_ctrl
module tb_v_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic        inst_ready_o;
    logic        flush_i;
    logic        issue_valid_o;
    logic [31:0] issue_inst_o;
    logic        wb_strobe_o;
    logic [4:0]  wb_vd_o;
    logic        busy_o;

    v_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .inst_valid_i  (inst_valid_i),
        .inst_i        (inst_i),
        .inst_ready_o  (inst_ready_o),
        .flush_i       (flush_i),
        .issue_valid_o (issue_valid_o),
        .issue_inst_o  (issue_inst_o),
        .wb_strobe_o   (wb_strobe_o),
        .wb_vd_o       (wb_vd_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t iq[$];
    exp_t wq[$];
    bit   mon_en = 1'b0;

    function automatic logic [31:0] opv(input logic [6:0] f7, input logic [4:0] vs2,
                                        input logic [4:0] vs1, input logic [2:0] f3,
                                        input logic [4:0] vd);
        return {f7, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] vld(input logic [4:0] vd);
        return {12'd0, 5'd0, 3'b000, vd, 7'b0000111};
    endfunction

    function automatic logic [31:0] vst(input logic [4:0] vs3);
        return {12'd0, 5'd0, 3'b000, vs3, 7'b0100111};
    endfunction

    function automatic int exp_lat(input logic [31:0] ins);
        logic [6:0] f7;
        f7 = ins[31:25];
        if (ins[6:0] == 7'b0000111) return 2;
        if (ins[6:0] == 7'b1010111) return (f7 == 7'b0000010 || f7 == 7'b0000110) ? 8 : 1;
        return 0;
    endfunction

    // Scoreboard drain: every cycle the observed strobes must match what is due
    bit          due_i, due_w;
    logic [31:0] exp_i, exp_w;
    int          hit;
    always @(negedge clk) begin
        if (mon_en) begin
            due_i = 1'b0; due_w = 1'b0; exp_i = '0; exp_w = '0;
            hit = -1;
            for (int k = 0; k < iq.size(); k++)
                if (iq[k].cyc == cyc && hit < 0) hit = k;
            if (hit >= 0) begin
                due_i = 1'b1; exp_i = iq[hit].val; iq.delete(hit);
            end
            hit = -1;
            for (int k = 0; k < wq.size(); k++)
                if (wq[k].cyc == cyc && hit < 0) hit = k;
            if (hit >= 0) begin
                due_w = 1'b1; exp_w = wq[hit].val; wq.delete(hit);
            end
            check_eq("issue_valid", {31'd0, issue_valid_o}, {31'd0, due_i});
            if (due_i) check_eq("issue_inst", issue_inst_o, exp_i);
            check_eq("wb_strobe", {31'd0, wb_strobe_o}, {31'd0, due_w});
            if (due_w) check_eq("wb_vd", {27'd0, wb_vd_o}, exp_w);
        end
    end

    task automatic offer(input logic [31:0] ins, input int exp_stall, input string tag);
        int waited;
        bit got;
        waited = 0;
        got = 1'b0;
        inst_valid_i = 1'b1;
        inst_i = ins;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (inst_ready_o) begin
                got = 1'b1;
                iq.push_back('{cyc: cyc + 1, val: ins});
                if (exp_lat(ins) > 0)
                    wq.push_back('{cyc: cyc + exp_lat(ins), val: {27'd0, ins[11:7]}});
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        inst_valid_i = 1'b0;
        check_eq({tag, "_accepted"}, {31'd0, got}, 32'd1);
        check_eq({tag, "_stall"}, waited, exp_stall);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic purge_after(input int c);
        for (int k = wq.size() - 1; k >= 0; k--)
            if (wq[k].cyc > c) wq.delete(k);
        for (int k = iq.size() - 1; k >= 0; k--)
            if (iq[k].cyc > c) iq.delete(k);
    endtask

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_DIV = 7'b0000110;

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        inst_valid_i = 1'b1;
        inst_i = opv(F7_ADD, 5'd2, 5'd1, 3'b000, 5'd3);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, inst_ready_o}, 32'd0);
        check_eq("rst_issue_valid", {31'd0, issue_valid_o}, 32'd0);
        check_eq("rst_issue_inst", issue_inst_o, 32'd0);
        check_eq("rst_wb_strobe", {31'd0, wb_strobe_o}, 32'd0);
        check_eq("rst_wb_vd", {27'd0, wb_vd_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        inst_valid_i = 1'b0;
        mon_en = 1'b1;

        // single vadd32 v3,v1,v2
        offer(opv(F7_ADD, 5'd2, 5'd1, 3'b000, 5'd3), 0, "vadd");
        idle(3);

        // vdiv32 v4 then dependent vadd32 v5,v4,v6
        offer(opv(F7_DIV, 5'd2, 5'd1, 3'b000, 5'd4), 0, "vdiv_v4");
        offer(opv(F7_ADD, 5'd4, 5'd6, 3'b000, 5'd5), 7, "raw_v5");
        idle(4);

        // load v1 then ALU v7: writeback-port collision
        offer(vld(5'd1), 0, "ld_v1");
        offer(opv(F7_ADD, 5'd0, 5'd0, 3'b000, 5'd7), 1, "collide_v7");
        idle(4);

        // fill the tracker, pass-through op is not blocked by full
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd8),  0, "div_v8");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd9),  0, "div_v9");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd10), 0, "div_v10");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd11), 0, "div_v11");
        offer(32'h0000_0013, 0, "passthru");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd12), 3, "full_v12");
        idle(12);

        // store reading an in-flight load target, then an unrelated one
        offer(vld(5'd2), 0, "ld_v2");
        offer(vst(5'd2), 1, "st_v2_dep");
        offer(vld(5'd3), 0, "ld_v3");
        offer(vst(5'd2), 0, "st_v2_free");
        idle(4);

        // non-OPIVV form does not read vs1 as a vreg
        offer(vld(5'd6), 0, "ld_v6");
        offer(opv(F7_DIV, 5'd0, 5'd6, 3'b100, 5'd9), 0, "opvx_vs1");
        idle(10);

        // flush with three entries in flight
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd8),  0, "fl_v8");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd9),  0, "fl_v9");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd10), 0, "fl_v10");
        flush_i = 1'b1;
        inst_valid_i = 1'b1;
        inst_i = opv(F7_ADD, 5'd0, 5'd0, 3'b000, 5'd20);
        purge_after(cyc);
        @(negedge clk);
        check_eq("flush_ready", {31'd0, inst_ready_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", {31'd0, busy_o}, 32'd0);
        check_eq("flush_issue_valid", {31'd0, issue_valid_o}, 32'd0);
        idle(12);

        // reset with three entries in flight
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd13), 0, "rs_v13");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd14), 0, "rs_v14");
        offer(opv(F7_DIV, 5'd0, 5'd0, 3'b000, 5'd15), 0, "rs_v15");
        idle(1);
        rst = 1'b1;
        purge_after(cyc - 1);
        @(negedge clk);
        check_eq("midrst_ready", {31'd0, inst_ready_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("midrst_issue_valid", {31'd0, issue_valid_o}, 32'd0);
        idle(12);

        check_eq("wbq_empty", wq.size(), 32'd0);
        check_eq("issueq_empty", iq.size(), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
